// File: rtl/alu_serial_sequencer_pkg.sv
// alu_serial_sequencer_pkg: shared FSM state type and ALU opcode constants
package alu_serial_sequencer_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;
    localparam int INV_A = 3;
    localparam int INV_B = 2;
endpackage

// File: rtl/alu_serial_sequencer.sv
// alu_serial_sequencer: drives an external 1-bit ALU slice LSB-first over WIDTH cycles
module alu_serial_sequencer
    import alu_serial_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       op_code,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [3:0]       slice_aluop,
    input  logic             slice_result,
    input  logic             slice_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             res_zero,
    output logic             res_err
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [3:0]       op_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q, cout_q, ovf_q, err_q;
    logic             run, is_add;
    assign run         = state_q == S_RUN;
    assign is_add      = op_q[1:0] == OP_ADD;
    assign slice_a     = run & a_q[idx_q];
    assign slice_b     = run & b_q[idx_q];
    // bit 0 takes the B-invert bit as carry-in so that ~B + 1 forms subtraction
    assign slice_cin   = run & is_add & ((idx_q == '0) ? op_q[INV_B] : carry_q);
    assign slice_aluop = run ? op_q : 4'b0000;
    assign op_ready    = state_q == S_IDLE;
    assign res_valid   = state_q == S_DONE;
    assign res_data    = res_q;
    assign res_cout    = cout_q;
    assign res_ovf     = ovf_q;
    assign res_err     = err_q;
    assign res_zero    = res_valid & ~err_q & ~|res_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (op_valid) begin
                    a_q     <= op_a;
                    b_q     <= op_b;
                    op_q    <= op_code;
                    idx_q   <= '0;
                    res_q   <= '0;
                    carry_q <= 1'b0;
                    cout_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                    err_q   <= op_code[1:0] == OP_ILL;
                    state_q <= (op_code[1:0] == OP_ILL) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    res_q[idx_q] <= slice_result;
                    carry_q      <= is_add & slice_cout;
                    idx_q        <= idx_q + 1'b1;
                    if (idx_q == IW'(WIDTH - 1)) begin
                        cout_q  <= is_add & slice_cout;
                        ovf_q   <= is_add & (slice_cin ^ slice_cout);
                        state_q <= S_DONE;
                    end
                end
                S_DONE: if (res_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
